decision_tx_sched: RTL

Sequences trading_logic decisions onto the byte-wide uart_tx.
- Queues each decision (type + price) in a small FIFO.
- Serialises each queued decision into a fixed 7-byte frame.
- Issues one byte at a time to uart_tx, pacing on its busy flag.
- Sits between trading_logic (decision_valid/decision_type/d_price) and uart_tx (data_in/data_valid/busy). It replaces the direct 32-bit wiring between them.

---
 rtl/trading_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/decision_tx_sched.sv | 126 ++++++++++++
 3 files changed

// File: rtl/trading_pkg.sv
// Shared types and constants for the decision-to-UART frame scheduler.
package trading_pkg;

    typedef struct packed {
        logic [7:0]  dtype;
        logic [31:0] price;
    } decision_t;

    localparam int unsigned FRAME_LEN         = 7;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } sched_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy level; push is ignored when full, pop when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned   AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LEVEL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/decision_tx_sched.sv
// Buffers trading decisions and serialises each into a 7-byte frame
// (sync, type, price MSB..LSB, xor checksum) paced by the UART busy flag.
module decision_tx_sched
    import trading_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          dec_valid,
    input  logic [7:0]                    dec_type,
    input  logic [31:0]                   dec_price,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_count,
    output logic                          ack_err,
    output logic                          idle
);

    localparam int unsigned TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [2:0]    LAST_IDX = 3'(FRAME_LEN - 1);

    sched_state_t  state;
    decision_t     head;
    decision_t     wdata;
    logic [39:0]   sreg;
    logic [2:0]    idx;
    logic [7:0]    chk;
    logic [7:0]    cur_byte;
    logic [TW-1:0] tmo;
    logic          full;
    logic          empty;
    logic          pop;
    logic          byte_done;

    assign wdata = '{dtype: dec_type, price: dec_price};
    assign pop   = (state == ST_LOAD);
    assign idle  = (state == ST_IDLE) && empty;

    sync_fifo #(
        .WIDTH ($bits(decision_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (dec_valid),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // Payload bytes come off the top of the shift register; sync and chk are injected by index.
    always_comb begin
        cur_byte = sreg[39:32];
        if (idx == '0)            cur_byte = SYNC_BYTE;
        else if (idx == LAST_IDX) cur_byte = chk;
    end

    // A timeout expiry leaves the byte the same way a busy fall does.
    assign byte_done = !tx_busy &&
                       ((state == ST_WAIT_DONE) ||
                        (state == ST_WAIT_ACK && tmo == TMO_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            idx        <= '0;
            chk        <= '0;
            tmo        <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            drop_count <= '0;
            ack_err    <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (dec_valid && full && drop_count != '1)
                drop_count <= drop_count + 1'b1;

            case (state)
                ST_IDLE: if (!empty) state <= ST_LOAD;
                ST_LOAD: begin
                    sreg  <= head;
                    idx   <= '0;
                    chk   <= '0;
                    state <= ST_SEND;
                end
                ST_SEND: if (!tx_busy) begin
                    tx_data  <= cur_byte;
                    tx_valid <= 1'b1;
                    if (idx != '0 && idx != LAST_IDX) begin
                        chk  <= chk ^ cur_byte;
                        sreg <= {sreg[31:0], 8'h00};
                    end
                    tmo   <= '0;
                    state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (tx_busy)               state   <= ST_WAIT_DONE;
                    else if (tmo == TMO_LAST)  ack_err <= 1'b1;
                    else                       tmo     <= tmo + 1'b1;
                end
                ST_WAIT_DONE: ;
                default: state <= ST_IDLE;
            endcase

            if (byte_done) begin
                if (idx == LAST_IDX) begin
                    state <= ST_IDLE;
                end else begin
                    idx   <= idx + 1'b1;
                    state <= ST_SEND;
                end
            end
        end
    end

endmodule
